// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds reset/bubble constants, the fetch FSM state encoding and the IF/ID
// register control operations.
package if_fetch_pkg;

  localparam logic        RST_ENA    = 1'b0;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  // IF/ID register action for the coming edge.
  typedef enum logic [1:0] {
    IdHold   = 2'd0,
    IdLoad   = 2'd1,
    IdBubble = 2'd2
  } id_op_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction ROM read port.
//   rena  : read enable (fetch -> ROM)
//   raddr : byte address, ROM decodes [31:2] (fetch -> ROM)
//   rdata : combinational read data for raddr (ROM -> fetch)
interface if_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  rena;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output rena, output raddr, input rdata);
  modport slave  (input rena, input raddr, output rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, arst_n      : clock, async active-low reset
//   op               : hold / load captured word / load bubble
//   inst_d, addr_d   : word and its address; addr_d also tags a bubble
//   inst, inst_addr  : registered instruction and address
//   inst_valid       : register holds a real instruction
module if_id_reg #(
  parameter int unsigned                  ADDR_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter logic        [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(if_fetch_pkg::NOP_INST),
  parameter logic        [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(if_fetch_pkg::RESET_PC)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  if_fetch_pkg::id_op_e   op,
  input  logic [DATA_WIDTH-1:0]  inst_d,
  input  logic [ADDR_WIDTH-1:0]  addr_d,
  output logic [DATA_WIDTH-1:0]  inst,
  output logic [ADDR_WIDTH-1:0]  inst_addr,
  output logic                   inst_valid
);
  import if_fetch_pkg::*;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inst       <= NOP_INST;
      inst_addr  <= RESET_PC;
      inst_valid <= 1'b0;
    end else begin
      unique case (op)
        IdLoad: begin
          inst       <= inst_d;
          inst_addr  <= addr_d;
          inst_valid <= 1'b1;
        end
        IdBubble: begin
          inst       <= NOP_INST;
          inst_addr  <= addr_d;
          inst_valid <= 1'b0;
        end
        default: ;  // IdHold
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads the ROM and fills IF/ID.
//   clk, arst_n   : clock, async active-low reset
//   stall_i       : hold PC and IF/ID
//   flush_i       : replace this cycle's fetch with a bubble, refetch same PC
//   jump_i        : redirect PC to jump_addr_i (misaligned target halts)
//   rom           : ROM read port (master side)
//   inst_o, inst_addr_o, inst_valid_o : IF/ID contents
//   misalign_o    : sticky misaligned-jump fault
module if_fetch #(
  parameter int unsigned                  ADDR_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter logic        [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(if_fetch_pkg::RESET_PC),
  parameter logic        [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(if_fetch_pkg::NOP_INST)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  if_fetch_if.master            rom,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic                  inst_valid_o,
  output logic                  misalign_o
);
  import if_fetch_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  id_op_e                id_op;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StWait;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Priority in RUN: jump > flush > stall > advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    id_op      = IdBubble;
    unique case (state_q)
      StWait: state_d = StRun;
      StRun: begin
        if (jump_i) begin
          // Target is taken even when misaligned so the faulting PC is visible.
          pc_d = jump_addr_i;
          if (jump_addr_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = StHalt;
          end
        end else if (flush_i) begin
          id_op = IdBubble;
        end else if (stall_i) begin
          id_op = IdHold;
        end else begin
          id_op = IdLoad;
          pc_d  = pc_q + ADDR_WIDTH'(4);
        end
      end
      default: ;  // StHalt: only reset leaves
    endcase
  end

  assign rom.rena   = (state_q == StRun);
  assign rom.raddr  = pc_q;
  assign misalign_o = misalign_q;

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INST   (NOP_INST),
    .RESET_PC   (RESET_PC)
  ) u_if_id_reg (
    .clk        (clk),
    .arst_n     (arst_n),
    .op         (id_op),
    .inst_d     (rom.rdata),
    .addr_d     (pc_q),
    .inst       (inst_o),
    .inst_addr  (inst_addr_o),
    .inst_valid (inst_valid_o)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, reset checks and
// randomized traffic against a behavioural model of the fetch stage.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o, misalign_o;

  int errors = 0;
  int checks = 0;

  if_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rom ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a >> 2)
      32'd0:   return 32'h0010_0093;
      32'd1:   return 32'h0020_0113;
      32'd2:   return 32'h0030_0193;
      32'd3:   return 32'h0040_0213;
      default: return ((a >> 2) * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endcase
  endfunction

  assign rom.rdata = rom_word(rom.raddr);

  if_fetch dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .rom          (rom.master),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: started/halted flags, PC and the IF/ID contents.
  logic [31:0] m_pc, m_inst, m_addr;
  bit          m_valid, m_mis, m_started, m_halted;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = NOP; m_addr = 32'h0;
    m_valid = 0; m_mis = 0; m_started = 0; m_halted = 0;
  endtask

  task automatic model_bubble();
    m_inst = NOP; m_addr = m_pc; m_valid = 0;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit j, input logic [31:0] ja);
    if (!m_started) begin
      m_started = 1;
      model_bubble();
    end else if (m_halted) begin
      model_bubble();
    end else if (j) begin
      model_bubble();
      m_pc = ja;
      if (ja % 4 != 0) begin
        m_mis = 1;
        m_halted = 1;
      end
    end else if (f) begin
      model_bubble();
    end else if (!s) begin
      m_inst = rom_word(m_pc); m_addr = m_pc; m_valid = 1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_inst"}, inst_o, m_inst);
    chk({tag, "_valid"}, {31'b0, inst_valid_o}, {31'b0, m_valid});
    chk({tag, "_mis"}, {31'b0, misalign_o}, {31'b0, m_mis});
    chk({tag, "_rena"}, {31'b0, rom.rena}, {31'b0, m_started && !m_halted});
    chk({tag, "_pc"}, rom.raddr, m_pc);
    if (!m_halted) chk({tag, "_addr"}, inst_addr_o, m_addr);
  endtask

  task automatic drive(input bit s, input bit f, input bit j, input logic [31:0] ja);
    stall_i = s; flush_i = f; jump_i = j; jump_addr_i = ja;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; values checked before any edge.
  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    #2;
    model_reset();
    chk({tag, "_inst"}, inst_o, NOP);
    chk({tag, "_addr"}, inst_addr_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'h0);
    chk({tag, "_mis"}, {31'b0, misalign_o}, 32'h0);
    chk({tag, "_rena"}, {31'b0, rom.rena}, 32'h0);
    chk({tag, "_pc"}, rom.raddr, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        s, f, j;
    logic [31:0] ja;
    logic [31:0] e_inst, e_addr;
    logic        e_valid, e_mis, e_rena;
    logic [31:0] e_pc;
    logic        addr_care;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic s, f, j, input logic [31:0] ja,
                              input logic [31:0] ei, ea, input logic ev, em, er,
                              input logic [31:0] ep, input logic ac);
    vec_t v;
    v.s = s; v.f = f; v.j = j; v.ja = ja;
    v.e_inst = ei; v.e_addr = ea; v.e_valid = ev; v.e_mis = em; v.e_rena = er;
    v.e_pc = ep; v.addr_care = ac;
    return v;
  endfunction

  task automatic run_vecs(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].s, vecs[i].f, vecs[i].j, vecs[i].ja);
      chk($sformatf("%s%0d_inst", tag, i), inst_o, vecs[i].e_inst);
      chk($sformatf("%s%0d_valid", tag, i), {31'b0, inst_valid_o}, {31'b0, vecs[i].e_valid});
      chk($sformatf("%s%0d_mis", tag, i), {31'b0, misalign_o}, {31'b0, vecs[i].e_mis});
      chk($sformatf("%s%0d_rena", tag, i), {31'b0, rom.rena}, {31'b0, vecs[i].e_rena});
      chk($sformatf("%s%0d_pc", tag, i), rom.raddr, vecs[i].e_pc);
      if (vecs[i].addr_care) chk($sformatf("%s%0d_addr", tag, i), inst_addr_o, vecs[i].e_addr);
    end
  endtask

  initial begin
    //               s  f  j  jaddr          inst                     addr           v  m  r  pc             ac
    vecs[0]  = mk(0, 0, 0, 32'h0,         NOP,                     32'h0,         0, 0, 1, 32'h0,         1);
    vecs[1]  = mk(0, 0, 0, 32'h0,         rom_word(32'h0),         32'h0,         1, 0, 1, 32'h4,         1);
    vecs[2]  = mk(0, 0, 0, 32'h0,         rom_word(32'h4),         32'h4,         1, 0, 1, 32'h8,         1);
    vecs[3]  = mk(1, 0, 0, 32'h0,         rom_word(32'h4),         32'h4,         1, 0, 1, 32'h8,         1);
    vecs[4]  = mk(1, 0, 0, 32'h0,         rom_word(32'h4),         32'h4,         1, 0, 1, 32'h8,         1);
    vecs[5]  = mk(1, 0, 0, 32'h0,         rom_word(32'h4),         32'h4,         1, 0, 1, 32'h8,         1);
    vecs[6]  = mk(0, 0, 0, 32'h0,         rom_word(32'h8),         32'h8,         1, 0, 1, 32'hC,         1);
    vecs[7]  = mk(0, 1, 0, 32'h0,         NOP,                     32'hC,         0, 0, 1, 32'hC,         1);
    vecs[8]  = mk(0, 0, 0, 32'h0,         rom_word(32'hC),         32'hC,         1, 0, 1, 32'h10,        1);
    vecs[9]  = mk(1, 0, 1, 32'h40,        NOP,                     32'h10,        0, 0, 1, 32'h40,        1);
    vecs[10] = mk(0, 0, 0, 32'h0,         rom_word(32'h40),        32'h40,        1, 0, 1, 32'h44,        1);
    vecs[11] = mk(0, 0, 1, 32'hFFFF_FFFC, NOP,                     32'h44,        0, 0, 1, 32'hFFFF_FFFC, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,         rom_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 0, 1, 32'h0,         1);
    vecs[13] = mk(0, 0, 0, 32'h0,         rom_word(32'h0),         32'h0,         1, 0, 1, 32'h4,         1);
    vecs[14] = mk(0, 0, 1, 32'h42,        NOP,                     32'h4,         0, 1, 0, 32'h42,        1);
    vecs[15] = mk(0, 0, 0, 32'h0,         NOP,                     32'h0,         0, 1, 0, 32'h42,        0);
    vecs[16] = mk(1, 1, 1, 32'h80,        NOP,                     32'h0,         0, 1, 0, 32'h42,        0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", inst_o, NOP);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_rena", {31'b0, rom.rena}, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("wait_rena", {31'b0, rom.rena}, 32'h0);

    run_vecs(0, 16, "v");

    // Reset while halted clears the fault; startup repeats.
    do_reset("halt_rst");
    run_vecs(0, 2, "rs");

    // Randomized traffic against the model.
    do_reset("rnd_rst");
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      bit s, f, j;
      logic [31:0] ja;
      r = $urandom_range(0, 99);
      if ((m_halted && r < 25) || r == 0) begin
        do_reset($sformatf("r%0d_rst", n));
      end else begin
        s = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 7) == 0);
        j = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 9))
          0:       ja = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
          1:       ja = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
          2:       ja = $urandom & 32'hFFFF_FFFC;
          default: ja = {$urandom_range(0, 63), 2'b00};
        endcase
        drive(s, f, j, ja);
        model_edge(s, f, j, ja);
        check_model($sformatf("r%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
